// File: rtl/mul_pkg.sv
// Shared constants for the multiplier datapath: operand widths and M-extension op codes.
package mul_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PROD_W = 64;

    // funct3[1:0] of the RISC-V multiply group
    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

endpackage

// File: rtl/mul_adder32.sv
// 32-bit carry-propagate adder with carry in/out, the building block of the tail adders.
module mul_adder32
    import mul_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            cin_i,
    output logic [XLEN-1:0] sum_o,
    output logic            cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{XLEN{1'b0}}, cin_i};

endmodule

// File: rtl/mul_final_adder64.sv
// Final 64-bit carry-propagate add of the Wallace sum vector and the pre-shifted carry vector.
module mul_final_adder64
    import mul_pkg::*;
(
    input  logic [PROD_W-1:0] s_i,
    input  logic [PROD_W-1:0] c_sh_i,
    output logic [PROD_W-1:0] sum_o
);

    logic lo_cout;
    // Carry out of the top half falls off: the product is taken mod 2^64
    logic unused_hi_cout;

    mul_adder32 u_add_lo (
        .a_i    (s_i[XLEN-1:0]),
        .b_i    (c_sh_i[XLEN-1:0]),
        .cin_i  (1'b0),
        .sum_o  (sum_o[XLEN-1:0]),
        .cout_o (lo_cout)
    );

    mul_adder32 u_add_hi (
        .a_i    (s_i[PROD_W-1:XLEN]),
        .b_i    (c_sh_i[PROD_W-1:XLEN]),
        .cin_i  (lo_cout),
        .sum_o  (sum_o[PROD_W-1:XLEN]),
        .cout_o (unused_hi_cout)
    );

endmodule

// File: rtl/booth_multiplier_tail.sv
// Tail of the Booth/Wallace multiplier: resolves the carry/sum pair, applies the unsigned
// high-word correction and selects the M-extension result through a two-stage pipeline.
module booth_multiplier_tail
    import mul_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_c,
    input  logic [PROD_W-1:0] in_s,
    input  logic [1:0]        in_op,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    // Stage 1 state. in_c[63] carries weight 2^64 and never matters, so it is not stored.
    logic              s1_valid_q, s1_valid_d;
    logic [PROD_W-2:0] s1_c_q;
    logic [PROD_W-1:0] s1_s_q;
    logic [1:0]        s1_op_q;
    logic [XLEN-1:0]   s1_rs1_q;
    logic [XLEN-1:0]   s1_rs2_q;
    logic [TAG_W-1:0]  s1_tag_q;

    // Stage 2 (output) state
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic [TAG_W-1:0]  out_tag_q;

    logic accept;
    logic advance;

    logic [PROD_W-1:0] prod;
    logic [XLEN-1:0]   prod_hi;
    logic [XLEN-1:0]   corr_y_term;
    logic [XLEN-1:0]   corr_x_term;
    logic [XLEN-1:0]   corr_sum;
    logic [XLEN-1:0]   corr_maj;
    logic [XLEN-1:0]   corr_carry;
    logic [XLEN-1:0]   hi_corrected;
    logic              unused_corr_bits;
    logic              unused_corr_cout;

    assign in_ready = ~s1_valid_q | ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign advance  = s1_valid_q & (~out_valid_q | out_ready);

    mul_final_adder64 u_final_adder (
        .s_i    (s1_s_q),
        .c_sh_i ({s1_c_q, 1'b0}),
        .sum_o  (prod)
    );

    assign prod_hi = prod[PROD_W-1:XLEN];

    // Signed-to-unsigned fix-up terms: +y when x is negative (MULHU only), +x when y is negative
    assign corr_y_term = (s1_op_q == MUL_OP_MULHU && s1_rs1_q[XLEN-1]) ? s1_rs2_q : '0;
    assign corr_x_term = ((s1_op_q == MUL_OP_MULHSU || s1_op_q == MUL_OP_MULHU) &&
                          s1_rs2_q[XLEN-1]) ? s1_rs1_q : '0;

    // 3:2 compression so a single carry-propagate add handles both correction terms
    assign corr_sum   = prod_hi ^ corr_y_term ^ corr_x_term;
    assign corr_maj   = (prod_hi & corr_y_term) | (prod_hi & corr_x_term) |
                        (corr_y_term & corr_x_term);
    assign corr_carry = {corr_maj[XLEN-2:0], 1'b0};

    // Shifted-out majority bit and final carry-out are weight 2^32: dropped for mod-2^32 result
    assign unused_corr_bits = corr_maj[XLEN-1];

    mul_adder32 u_corr_adder (
        .a_i    (corr_sum),
        .b_i    (corr_carry),
        .cin_i  (1'b0),
        .sum_o  (hi_corrected),
        .cout_o (unused_corr_cout)
    );

    // Result select: low word for MUL, corrected high word otherwise
    always_comb begin
        out_result_d = hi_corrected;
        case (s1_op_q)
            MUL_OP_MUL: out_result_d = prod[XLEN-1:0];
            default:    out_result_d = hi_corrected;
        endcase
    end

    // Valid next-state: flush wins, then capture/advance/consume
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (advance) begin
                s1_valid_d = 1'b0;
            end
            if (advance) begin
                out_valid_d = 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Valid flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Stage 1 data capture; flushed entries leave their stale data behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_c_q   <= '0;
            s1_s_q   <= '0;
            s1_op_q  <= MUL_OP_MUL;
            s1_rs1_q <= '0;
            s1_rs2_q <= '0;
            s1_tag_q <= '0;
        end else if (accept) begin
            s1_c_q   <= in_c[PROD_W-2:0];
            s1_s_q   <= in_s;
            s1_op_q  <= in_op;
            s1_rs1_q <= in_rs1;
            s1_rs2_q <= in_rs2;
            s1_tag_q <= in_tag;
        end
    end

    // Output registers load only on advance, so they hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else if (advance && !flush) begin
            out_result_q <= out_result_d;
            out_tag_q    <= s1_tag_q;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign busy       = s1_valid_q | out_valid_q;

endmodule

// File: doc/booth_multiplier_tail.md
Name: booth_multiplier_tail

Overview:
- Final stage of the 32x32 Booth/Wallace multiplier.
- Consumes the 64-bit carry/sum vector pair produced by the Wallace reduction and adds them with a carry-propagate adder.
- Applies the unsigned high-word correction and selects the RISC-V M-extension result: MUL, MULH, MULHSU or MULHU.
- Two-stage valid/ready pipeline between the multiplier head and execute-stage writeback.

Parameters:
TAG_W, 5, width of the opaque destination tag carried alongside each operation (rd index)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill all in-flight operations
in_valid  in  1  head presents a valid C/S pair
in_ready  out  1  tail accepts this cycle
in_c  in  64  Wallace carry vector, bit j has weight 2^(j+1)
in_s  in  64  Wallace sum vector, bit j has weight 2^j
in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
in_rs1  in  32  original multiplicand x
in_rs2  in  32  original multiplier y
in_tag  in  TAG_W  destination tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  32  selected 32-bit result
out_tag  out  TAG_W  tag of out_result
busy  out  1  either stage holds a valid operation

Behaviour:
- Reset and clocking: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: s1_valid=0, out_valid=0, out_result=0, out_tag=0, all stage data registers 0. After reset, in_ready=1 and busy=0.
- Stage 1 (capture):
  - Accept when in_valid & in_ready & ~flush.
  - Register in_c, in_s, in_op, in_rs1, in_rs2, in_tag; set s1_valid.
- Stage 1 arithmetic, registered into stage 2:
  - P = in_s + {in_c[62:0],1'b0}, mod 2^64. in_c[63] is discarded.
  - P is the signed(x) * signed(y) product. Booth negation +1 terms are already folded in by the head via the Wallace cin.
- Correction, all mod 2^32, applied to H = P[63:32]:
  - MULH: H unchanged.
  - MULHSU: H += (y[31] ? x : 0).
  - MULHU: H += (x[31] ? y : 0) + (y[31] ? x : 0).
- Result select: MUL returns P[31:0]. The three high ops return corrected H.
- Split of work across stages:
  - The 64-bit add is done in the stage-1→2 path.
  - The correction add and op mux are in the same path.
  - Output registers feed out_result directly: no combinational path from in_* to out_*.
- Latency: 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 op/cycle.
- Handshake:
  - Stage 2 advances when s1_valid & (~out_valid | out_ready).
  - in_ready = ~s1_valid | (~out_valid | out_ready). This is combinational and does not depend on in_valid.
  - A result is consumed on out_valid & out_ready.
  - out_result and out_tag are held stable while out_valid & ~out_ready.
  - With stage 2 stalled and stage 1 full, in_ready=0 and stage 1 holds.
- Simultaneous consume and advance: stage 2 reloads in the same cycle. There is no bubble.
- Flush:
  - Next cycle s1_valid=0 and out_valid=0.
  - Input is not accepted in the flush cycle, even if in_valid & in_ready.
  - Data registers keep their stale values and are not cleared.
- busy = s1_valid | out_valid.
- Reset mid-operation: all valids clear immediately (asynchronous). No output is produced for ops in flight.

Decomposition:
- Shared package `mul_pkg`:
  - op encodings MUL_OP_MUL=2'b00, MUL_OP_MULH=2'b01, MUL_OP_MULHSU=2'b10, MUL_OP_MULHU=2'b11.
  - Widths XLEN=32 and PROD_W=64.
- One natural sub-module, `mul_final_adder64`:
  - Combinational 64-bit add built from two adder32 instances, with the low carry-out chained to the high carry-in.
  - Takes s and c<<1 and outputs the 64-bit sum.
- The correction adder uses a third adder32 plus a 3:2 step for MULHU.

Test Plan:
1. MUL, -2*3: in_s=64'hFFFF_FFFF_FFFF_FFFA, in_c=0, rs1=32'hFFFF_FFFE, rs2=3 → out_result=32'hFFFF_FFFA. The same inputs with MULH → 32'hFFFF_FFFF.
2. Carry across bit 31: in_s=64'h0000_0000_FFFF_FFFF, in_c=64'h1, op=MULH → out_result=32'h0000_0001. The same inputs with MUL → 32'h0000_0001.
3. MULHU: rs1=rs2=32'hFFFF_FFFF, in_s=1, in_c=0 → out_result=32'hFFFF_FFFE. MULHSU with the same operands and in_s=1 → 32'hFFFF_FFFF.
4. Back-to-back with backpressure: 4 ops on consecutive cycles, out_ready held low for 3 cycles after the first out_valid. Required response:
   - in_ready drops after 2 accepts.
   - out_result and out_tag stay stable while stalled.
   - All 4 results appear in order with correct tags.
   - No op is lost or duplicated.
5. Flush:
   - Flush asserted with both stages full and in_valid=1 → next cycle out_valid=0, busy=0, and the flush-cycle input is not captured.
   - A new op issued afterwards returns in 2 cycles.
6. Mid-op reset: assert rst_n=0 asynchronously while out_valid=1 → out_valid, out_result and out_tag go to 0 immediately, and in_ready=1 after release.
